// File: rtl/cpu_pkg.sv
// Shared widths, ALU opcodes and the operand bundle handed from the operand stage to the ALU.
package cpu_pkg;

    localparam int DW   = 8;
    localparam int NREG = 8;
    localparam int RW   = $clog2(NREG);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_RXOR = 4'b0101,
        ALU_NOT  = 4'b0110,
        ALU_SHL  = 4'b1110,
        ALU_SHR  = 4'b1111
    } alu_op_t;

    typedef struct packed {
        logic [3:0]    cmd;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [RW-1:0] rd;
    } alu_bundle_t;

endpackage

// File: rtl/reg_file.sv
// Architectural register file: one write port, two combinational read ports that
// forward the same-cycle writeback value.
module reg_file #(
    parameter int DW   = cpu_pkg::DW,
    parameter int NREG = cpu_pkg::NREG,
    parameter int RW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [RW-1:0] ra,
    input  logic [RW-1:0] rb,
    output logic [DW-1:0] rd_a,
    output logic [DW-1:0] rd_b,
    input  logic          wb_en,
    input  logic [RW-1:0] wb_rd,
    input  logic [DW-1:0] wb_data
);

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];

    always_comb begin
        regs_d = regs_q;
        if (wb_en) begin
            regs_d[wb_rd] = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // A writeback landing this cycle is visible to a read in the same cycle.
    assign rd_a = (wb_en && (wb_rd == ra)) ? wb_data : regs_q[ra];
    assign rd_b = (wb_en && (wb_rd == rb)) ? wb_data : regs_q[rb];

endmodule

// File: rtl/operand_stage.sv
// Operand-fetch stage: reads operands, tracks pending destinations, and registers
// one ALU bundle per accepted instruction.
module operand_stage #(
    parameter int DW   = cpu_pkg::DW,
    parameter int NREG = cpu_pkg::NREG,
    parameter int RW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_cmd,
    input  logic [RW-1:0] in_ra,
    input  logic [RW-1:0] in_rb,
    input  logic [RW-1:0] in_rd,
    input  logic          in_imm_en,
    input  logic [DW-1:0] in_imm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    alu_cmd,
    output logic [DW-1:0] inA,
    output logic [DW-1:0] inB,
    output logic [RW-1:0] out_rd,
    input  logic          wb_en,
    input  logic [RW-1:0] wb_rd,
    input  logic [DW-1:0] wb_data
);

    // Handshake: a transfer happens on a rising edge where valid && ready; ready never
    // looks at valid, and the producer holds its payload stable while valid && !ready.

    logic [DW-1:0]        rf_a;
    logic [DW-1:0]        rf_b;
    logic [NREG-1:0]      pend_q;
    logic [NREG-1:0]      pend_d;
    logic                 out_valid_q;
    logic                 out_valid_d;
    cpu_pkg::alu_bundle_t bundle_q;
    cpu_pkg::alu_bundle_t bundle_d;
    logic                 hazard_a;
    logic                 hazard_b;
    logic                 hazard_d;
    logic                 accept;

    reg_file #(.DW(DW), .NREG(NREG), .RW(RW)) u_reg_file (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra      (in_ra),
        .rb      (in_rb),
        .rd_a    (rf_a),
        .rd_b    (rf_b),
        .wb_en   (wb_en),
        .wb_rd   (wb_rd),
        .wb_data (wb_data)
    );

    // Sources covered by a same-cycle writeback are bypassed; a pending destination never is.
    assign hazard_a = pend_q[in_ra] && !(wb_en && (wb_rd == in_ra));
    assign hazard_b = !in_imm_en && pend_q[in_rb] && !(wb_en && (wb_rd == in_rb));
    assign hazard_d = pend_q[in_rd];

    assign in_ready = !(hazard_a || hazard_b || hazard_d) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        pend_d = pend_q;
        if (wb_en) begin
            pend_d[wb_rd] = 1'b0;
        end
        if (accept) begin
            pend_d[in_rd] = 1'b1;
        end
    end

    always_comb begin
        bundle_d    = bundle_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            bundle_d.cmd = in_cmd;
            bundle_d.a   = rf_a;
            bundle_d.b   = in_imm_en ? in_imm : rf_b;
            bundle_d.rd  = in_rd;
            out_valid_d  = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
        end else begin
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_cmd   = bundle_q.cmd;
    assign inA       = bundle_q.a;
    assign inB       = bundle_q.b;
    assign out_rd    = bundle_q.rd;

endmodule
